pupil_line_capture: RTL and testbench

//  Camera-side producer of packed grayscale image lines for pupil_detect. Packs the inward camera's
//  8-bit pixel stream into MAX_RESOLUTION-pixel lines in ping-pong line buffers. Presents one complete

---
 rtl/pupil_pkg.sv | 19 +
 rtl/pupil_line_buf.sv | 55 +++++
 rtl/pupil_line_capture.sv | 143 ++++++++++++++
 tb/tb_pupil_line_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pupil_pkg.sv
// Shared constants and types for the pupil capture/detect path.
package pupil_pkg;

    localparam int unsigned MAX_RESOLUTION  = 112;
    localparam int unsigned LINES_PER_FRAME = 112;
    localparam int unsigned PIX_W           = 8;
    localparam int unsigned LINE_W          = MAX_RESOLUTION * PIX_W;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned IDX_W           = $clog2(MAX_RESOLUTION);

    typedef logic [CNT_W-1:0] line_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pupil_line_buf.sv
// One line buffer: byte-addressed pixel storage, a full flag and the line tag of its contents.
module pupil_line_buf
    import pupil_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic              set_full_i,
    input  logic              clr_full_i,
    input  line_idx_t         tag_i,
    output logic [LINE_W-1:0] data_o,
    output logic              full_o,
    output line_idx_t         tag_o
);

    logic [PIX_W-1:0] mem_q [MAX_RESOLUTION];
    logic             full_q;
    line_idx_t        tag_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MAX_RESOLUTION; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Completion (set) and release (clear) never target the same buffer in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            tag_q  <= '0;
        end else if (set_full_i) begin
            full_q <= 1'b1;
            tag_q  <= tag_i;
        end else if (clr_full_i) begin
            full_q <= 1'b0;
        end
    end

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < MAX_RESOLUTION; i++) begin
            data_o[PIX_W*i +: PIX_W] = mem_q[i];
        end
    end

    assign full_o = full_q;
    assign tag_o  = tag_q;

endmodule

// File: rtl/pupil_line_capture.sv
// Packs the camera pixel stream into ping-pong line buffers and presents whole lines over valid/ack.
module pupil_line_capture
    import pupil_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cam_frame_start,
    input  logic              cam_pixel_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    input  logic              line_ack,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output line_idx_t         line_number,
    output logic              frame_capture_done,
    output logic              overflow
);

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    line_idx_t        line_cnt_q, line_cnt_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic             drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [1:0]        full, full_e, set_full, clr_full, buf_wr_en;
    logic [LINE_W-1:0] buf_data [2];
    line_idx_t         buf_tag [2];

    // Effective view of the counters for this cycle: frame_start clears them ahead of its own pixel.
    logic [CNT_W-1:0] pix_e;
    line_idx_t        line_e;
    logic             wr_e, rd_e, drop_e, acc, last_pix;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_full   = '0;
        clr_full   = '0;
        buf_wr_en  = '0;
        done_d     = 1'b0;
        drop_d     = drop_q;

        pix_e      = cam_frame_start ? '0 : pix_cnt_q;
        line_e     = cam_frame_start ? '0 : line_cnt_q;
        wr_e       = !cam_frame_start && wr_sel_q;
        rd_e       = !cam_frame_start && rd_sel_q;
        full_e     = cam_frame_start ? 2'b00 : full;
        overflow_d = !cam_frame_start && overflow_q;
        acc        = cam_pixel_valid && (cam_frame_start || (state_q == ST_CAPTURE));
        last_pix   = (pix_e == CNT_W'(MAX_RESOLUTION - 1));
        drop_e     = (pix_e == '0) ? full_e[wr_e] : drop_q;

        pix_cnt_d  = pix_e;
        line_cnt_d = line_e;
        wr_sel_d   = wr_e;
        rd_sel_d   = rd_e;

        if (cam_frame_start) begin
            state_d  = ST_CAPTURE;
            clr_full = 2'b11;
        end

        if (acc) begin
            drop_d          = drop_e;
            buf_wr_en[wr_e] = !drop_e;
            if ((pix_e == '0) && drop_e) begin
                overflow_d = 1'b1;
            end
            if (last_pix) begin
                pix_cnt_d  = '0;
                line_cnt_d = line_e + 1'b1;
                // A dropped line leaves wr_sel alone so buffers keep being read in line order.
                if (!drop_e) begin
                    set_full[wr_e] = 1'b1;
                    wr_sel_d       = !wr_e;
                end
                if (line_e == CNT_W'(LINES_PER_FRAME - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                pix_cnt_d = pix_e + 1'b1;
            end
        end

        if (line_ack && full_e[rd_e]) begin
            clr_full[rd_e] = 1'b1;
            rd_sel_d       = !rd_e;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        pupil_line_buf u_buf (
            .clk_i      (clock),
            .rst_ni     (reset_n),
            .wr_en_i    (buf_wr_en[b]),
            .wr_idx_i   (IDX_W'(pix_e)),
            .wr_data_i  (cam_pixel),
            .set_full_i (set_full[b]),
            .clr_full_i (clr_full[b]),
            .tag_i      (line_e),
            .data_o     (buf_data[b]),
            .full_o     (full[b]),
            .tag_o      (buf_tag[b])
        );
    end

    assign line_valid         = full[rd_sel_q];
    assign line_data          = buf_data[rd_sel_q];
    assign line_number        = buf_tag[rd_sel_q];
    assign frame_capture_done = done_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_pupil_line_capture.sv
// Bench for pupil_line_capture: a two-entry line queue model checked every cycle, plus directed cases.
module tb_pupil_line_capture;
    import pupil_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cam_frame_start;
    logic              cam_pixel_valid;
    logic [PIX_W-1:0]  cam_pixel;
    logic              line_ack;
    logic [LINE_W-1:0] line_data;
    logic              line_valid;
    line_idx_t         line_number;
    logic              frame_capture_done;
    logic              overflow;

    pupil_line_capture dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .cam_frame_start    (cam_frame_start),
        .cam_pixel_valid    (cam_pixel_valid),
        .cam_pixel          (cam_pixel),
        .line_ack           (line_ack),
        .line_data          (line_data),
        .line_valid         (line_valid),
        .line_number        (line_number),
        .frame_capture_done (frame_capture_done),
        .overflow           (overflow)
    );

    always #5 clock = ~clock;

    // Reference: presented lines form an in-order queue of at most two complete lines.
    typedef struct {
        line_idx_t         num;
        logic [LINE_W-1:0] data;
    } mline_t;

    mline_t            mq[$];
    int                m_pix, m_line;
    bit                m_cap, m_drop, m_ovf, m_done;
    logic [LINE_W-1:0] m_cur;

    int    vec_cnt = 0;
    int    err_cnt = 0;
    int    done_seen = 0;
    string phase = "reset";

    task automatic cmp(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s/%s: actual %0h required %0h", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pix  = 0;
        m_line = 0;
        m_cap  = 1'b0;
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_cur  = '0;
    endtask

    task automatic model_step(input bit st, input bit vld, input logic [7:0] px, input bit ack);
        bit     pre_full;
        mline_t e;
        m_done = 1'b0;
        if (st) begin
            mq.delete();
            m_pix  = 0;
            m_line = 0;
            m_ovf  = 1'b0;
            m_cap  = 1'b1;
        end
        pre_full = (mq.size() == 2);
        if (ack && mq.size() > 0) mq.delete(0);
        if (m_cap && vld) begin
            if (m_pix == 0) begin
                m_drop = pre_full;
                if (pre_full) m_ovf = 1'b1;
            end
            m_cur[PIX_W*m_pix +: PIX_W] = px;
            if (m_pix == MAX_RESOLUTION - 1) begin
                if (!m_drop) begin
                    e.num  = line_idx_t'(m_line);
                    e.data = m_cur;
                    mq.push_back(e);
                end
                if (m_line == LINES_PER_FRAME - 1) begin
                    m_done = 1'b1;
                    m_cap  = 1'b0;
                end
                m_pix = 0;
                m_line++;
            end else begin
                m_pix++;
            end
        end
    endtask

    task automatic check_model();
        bit ev;
        ev = (mq.size() > 0);
        cmp("valid", LINE_W'(line_valid), LINE_W'(ev));
        cmp("overflow", LINE_W'(overflow), LINE_W'(m_ovf));
        cmp("done", LINE_W'(frame_capture_done), LINE_W'(m_done));
        if (ev) begin
            cmp("number", LINE_W'(line_number), LINE_W'(mq[0].num));
            cmp("data", line_data, mq[0].data);
        end
    endtask

    task automatic cyc(input bit st, input bit vld, input logic [7:0] px, input bit ack);
        @(negedge clock);
        cam_frame_start = st;
        cam_pixel_valid = vld;
        cam_pixel       = px;
        line_ack        = ack;
        @(posedge clock);
        model_step(st, vld, px, ack);
        #1;
        if (frame_capture_done) done_seen++;
        check_model();
    endtask

    task automatic feed_line(input int seed, input bit auto_ack);
        for (int n = 0; n < MAX_RESOLUTION; n++) begin
            cyc(1'b0, 1'b1, 8'(seed + n), auto_ack && (mq.size() > 0));
        end
    endtask

    task automatic check_zero_outputs();
        cmp("rst_valid", LINE_W'(line_valid), '0);
        cmp("rst_number", LINE_W'(line_number), '0);
        cmp("rst_data", line_data, '0);
        cmp("rst_done", LINE_W'(frame_capture_done), '0);
        cmp("rst_overflow", LINE_W'(overflow), '0);
    endtask

    localparam int OP_LINE = 0;
    localparam int OP_ACK  = 1;

    typedef struct {
        int   op;
        bit   e_valid;
        logic [7:0] e_num;
        bit   e_ovf;
    } step_t;

    step_t steps[7];
    logic [LINE_W-1:0] exp_line;

    initial begin
        steps[0] = '{OP_LINE, 1'b1, 8'd0, 1'b0};
        steps[1] = '{OP_LINE, 1'b1, 8'd0, 1'b0};
        steps[2] = '{OP_LINE, 1'b1, 8'd0, 1'b1};
        steps[3] = '{OP_ACK,  1'b1, 8'd1, 1'b1};
        steps[4] = '{OP_ACK,  1'b0, 8'd0, 1'b1};
        steps[5] = '{OP_LINE, 1'b1, 8'd3, 1'b1};
        steps[6] = '{OP_ACK,  1'b0, 8'd0, 1'b1};

        reset_n         = 1'b0;
        cam_frame_start = 1'b0;
        cam_pixel_valid = 1'b0;
        cam_pixel       = '0;
        line_ack        = 1'b0;
        model_reset();
        #12;
        check_zero_outputs();
        reset_n = 1'b1;

        // Single line, pixel n = n, no ack.
        phase = "t1";
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int n = 0; n < MAX_RESOLUTION; n++) begin
            if (n == MAX_RESOLUTION - 1) cmp("pre_last_valid", LINE_W'(line_valid), '0);
            cyc(1'b0, 1'b1, 8'(n), 1'b0);
        end
        for (int n = 0; n < MAX_RESOLUTION; n++) exp_line[8*n +: 8] = 8'(n);
        cmp("t1_valid", LINE_W'(line_valid), LINE_W'(1'b1));
        cmp("t1_number", LINE_W'(line_number), '0);
        cmp("t1_data", line_data, exp_line);

        // Full frame, ack one cycle after each line appears.
        phase = "t2";
        done_seen = 0;
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int l = 0; l < LINES_PER_FRAME; l++) feed_line(l * 3, 1'b1);
        cmp("t2_last_number", LINE_W'(line_number), LINE_W'(8'd111));
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
        cyc(1'b0, 1'b1, 8'd5, 1'b0);
        cmp("t2_done_count", LINE_W'(done_seen), LINE_W'(1));
        cmp("t2_overflow", LINE_W'(overflow), '0);
        cmp("t2_valid_after", LINE_W'(line_valid), '0);

        // Drop and release sequence from a table.
        phase = "t3";
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int s = 0; s < 7; s++) begin
            if (steps[s].op == OP_LINE) feed_line(s * 17, 1'b0);
            else cyc(1'b0, 1'b0, 8'd0, 1'b1);
            cmp($sformatf("step%0d_valid", s), LINE_W'(line_valid), LINE_W'(steps[s].e_valid));
            cmp($sformatf("step%0d_ovf", s), LINE_W'(overflow), LINE_W'(steps[s].e_ovf));
            if (steps[s].e_valid) cmp($sformatf("step%0d_num", s), LINE_W'(line_number), LINE_W'(steps[s].e_num));
        end

        // Frame restart in the middle of line 5 while lines are held and overflow is set.
        phase = "t4";
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int l = 0; l < 5; l++) feed_line(l + 40, 1'b0);
        for (int n = 0; n < 50; n++) cyc(1'b0, 1'b1, 8'(n), 1'b0);
        cmp("t4_pre_ovf", LINE_W'(overflow), LINE_W'(1'b1));
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        cmp("t4_valid", LINE_W'(line_valid), '0);
        cmp("t4_ovf", LINE_W'(overflow), '0);
        for (int n = 1; n < MAX_RESOLUTION; n++) cyc(1'b0, 1'b1, 8'(n), 1'b0);
        cmp("t4_number", LINE_W'(line_number), '0);
        cmp("t4_pix0", LINE_W'(line_data[7:0]), LINE_W'(8'hAA));

        // Ack on the same edge as completion with the other buffer full.
        phase = "t5";
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        feed_line(9, 1'b0);
        for (int n = 0; n < MAX_RESOLUTION - 1; n++) cyc(1'b0, 1'b1, 8'(n + 100), 1'b0);
        cyc(1'b0, 1'b1, 8'd7, 1'b1);
        cmp("t5_number", LINE_W'(line_number), LINE_W'(8'd1));
        cmp("t5_valid", LINE_W'(line_valid), LINE_W'(1'b1));
        feed_line(200, 1'b0);
        cmp("t5_ovf", LINE_W'(overflow), '0);
        cmp("t5_held", LINE_W'(line_number), LINE_W'(8'd1));

        // Asynchronous reset mid-frame.
        phase = "t6";
        cyc(1'b1, 1'b1, 8'h11, 1'b0);
        feed_line(3, 1'b0);
        for (int n = 0; n < 30; n++) cyc(1'b0, 1'b1, 8'(n), 1'b0);
        #3;
        reset_n         = 1'b0;
        cam_pixel_valid = 1'b0;
        cam_frame_start = 1'b0;
        line_ack        = 1'b0;
        model_reset();
        #1;
        check_zero_outputs();
        #2;
        reset_n = 1'b1;
        for (int n = 0; n < 2 * MAX_RESOLUTION; n++) cyc(1'b0, 1'b1, 8'(n), 1'b0);
        cmp("t6_ignored", LINE_W'(line_valid), '0);
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        feed_line(77, 1'b0);
        cmp("t6_after_start", LINE_W'(line_valid), LINE_W'(1'b1));

        // Randomized traffic: partial frames with restarts, then one long frame.
        phase = "rand";
        for (int seg = 0; seg < 3; seg++) begin
            cyc(1'b1, 1'($urandom_range(1)), 8'($urandom), 1'b0);
            for (int c = 0; c < 1500; c++) begin
                cyc(($urandom_range(999) == 0), ($urandom_range(99) < 80), 8'($urandom),
                    ($urandom_range(99) < 35));
            end
        end
        cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
        for (int c = 0; c < 15000; c++) begin
            cyc(1'b0, ($urandom_range(99) < 92), 8'($urandom), ($urandom_range(99) < 30));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
